pwm_deadtime: RTL and testbench
===============================

PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have parameter BITS, default 8, counter/compare width.
REQ-002 SHALL have parameter DT_BITS, default 4, dead-time field width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ena, input, 1, channel enable; same signal that drives the upstream counter enable.
REQ-006 SHALL have port cnt_in, input, BITS, upstream up-counter value.
REQ-007 SHALL have port ovf_in, input, 1, upstream period-end strobe (counter == top while enabled).
REQ-008 SHALL have port cmp_in, input, BITS, new compare (duty) value.
REQ-009 SHALL have port cmp_wr, input, 1, one-cycle write strobe for cmp_in.
REQ-010 SHALL have port dt, input, DT_BITS, dead time in clk cycles, sampled at each dead-phase entry.
REQ-011 SHALL have port pol, input, 1, output polarity; 1 inverts both outputs.
REQ-012 SHALL have port pwm_h, output, 1, high-side drive.
REQ-013 SHALL have port pwm_l, output, 1, low-side drive.
REQ-014 SHALL have port upd_pend, output, 1, shadow compare written and not yet applied.

Function
REQ-015 SHALL hold cmp_shadow and cmp_active registers, BITS wide each.
REQ-016 cmp_wr SHALL load cmp_in into cmp_shadow and set upd_pend on the next edge; a later write overwrites it.
REQ-017 On a cycle with ovf_in=1 and ena=1, SHALL copy cmp_shadow to cmp_active and clear upd_pend.
REQ-018 cmp_wr coincident with ovf_in=1 and ena=1 SHALL load cmp_in directly into both registers and leave upd_pend=0.
REQ-019 SHALL register raw_q <= (cnt_in < cmp_active), unsigned; cmp_active=0 gives raw_q always 0; cmp_active > top gives raw_q always 1.
REQ-020 SHALL implement FSM with states LO, DEAD_H, HI, DEAD_L and a DT_BITS down-counter.
REQ-021 LO with raw_q=1: dt=0 -> HI; else -> DEAD_H with counter loaded dt-1.
REQ-022 HI with raw_q=0: dt=0 -> LO; else -> DEAD_L with counter loaded dt-1.
REQ-023 DEAD_H/DEAD_L: while counter != 0, decrement; at counter 0, go to HI (DEAD_H) or LO (DEAD_L).
REQ-024 DEAD_H with raw_q=0 SHALL return to LO on the next edge; DEAD_L with raw_q=1 SHALL go to HI on the next edge; the counter is not used in either case.
REQ-025 Outputs SHALL be registered decodes: pwm_h = (state==HI)^pol, pwm_l = (state==LO)^pol; pwm_h and pwm_l are never both active.
REQ-026 Latency: cnt_in value at edge N gives raw_q at N+1 and state change at N+2. Active output changes at N+2 for dt=0, or at N+2+dt for dt>0. Both outputs are inactive for exactly dt cycles.
REQ-027 ena=0 SHALL force the state to DEAD_L with the counter loaded dt-1 (LO if dt=0), with both outputs inactive. The shadow and write logic keep running.

Reset
REQ-028 rst low SHALL immediately set cmp_shadow=0, cmp_active=0, upd_pend=0, raw_q=0, counter=0, state=DEAD_L.
REQ-029 During reset both outputs SHALL be inactive: pwm_h=pol, pwm_l=pol.
REQ-030 After rst release, the FSM SHALL leave DEAD_L per REQ-023/024, reaching LO after dt cycles (or immediately when dt=0).

Verification
REQ-031 Reset: pol=0, assert rst mid-HI -> pwm_h=pwm_l=0 at once, upd_pend=0; release with dt=3 -> pwm_l=1 after 3 cycles.
REQ-032 Shadow: top=9, cmp=4 active, write 7 at cnt=2 -> upd_pend=1, duty stays 4 this period, 7 from the next; upd_pend clears at ovf.
REQ-033 Dead time: top=9, cmp=4, dt=2 -> per 10-cycle period pwm_h=1 for 2 cycles, pwm_l=1 for 4, both 0 for two 2-cycle gaps.
REQ-034 Short pulse: cmp=1, dt=3 -> FSM enters DEAD_H and returns to LO; pwm_h never asserts; pwm_l drops for only 1 cycle.
REQ-035 Simultaneous: cmp_wr=1 with cmp_in=6 on the ovf cycle -> cmp_active=6 next edge, upd_pend stays 0.
REQ-036 Disable/polarity: pol=1, ena drops in HI -> pwm_h=pwm_l=1 (inactive) next edge; re-enable resumes after dt.

Source files
------------

// File: rtl/pwm_deadtime.sv
// ----------------------------------------------------------------------------
// pwm_deadtime
// Complementary PWM channel with a double-buffered compare value and
// configurable dead time between the high-side and low-side drives.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : asynchronous active-low reset
//   ena       : channel enable (shared with the upstream counter)
//   cnt_in    : upstream up-counter value
//   ovf_in    : upstream period-end strobe (counter == top while enabled)
//   cmp_in    : new compare (duty) value
//   cmp_wr    : one-cycle write strobe for cmp_in
//   dt        : dead time in clk cycles, sampled on entry to a dead phase
//   pol       : output polarity, 1 inverts both drives
//   pwm_h     : high-side drive
//   pwm_l     : low-side drive
//   upd_pend  : shadow compare written but not yet applied
// ----------------------------------------------------------------------------
module pwm_deadtime #(
    parameter int BITS    = 8,
    parameter int DT_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [BITS-1:0]    cnt_in,
    input  logic               ovf_in,
    input  logic [BITS-1:0]    cmp_in,
    input  logic               cmp_wr,
    input  logic [DT_BITS-1:0] dt,
    input  logic               pol,
    output logic               pwm_h,
    output logic               pwm_l,
    output logic               upd_pend
);

    typedef enum logic [1:0] {
        ST_LO     = 2'd0,
        ST_DEAD_H = 2'd1,
        ST_HI     = 2'd2,
        ST_DEAD_L = 2'd3
    } state_e;

    localparam logic [DT_BITS-1:0] DT_ZERO = DT_BITS'(1'b0);
    localparam logic [DT_BITS-1:0] DT_ONE  = DT_BITS'(1'b1);
    localparam logic [DT_BITS-1:0] DT_TWO  = DT_BITS'(2'd2);

    logic [BITS-1:0]    cmp_shadow_q;
    logic [BITS-1:0]    cmp_active_q;
    logic               upd_pend_q;
    logic               raw_q;
    state_e             state_q;
    state_e             state_d;
    logic [DT_BITS-1:0] dcnt_q;
    logic [DT_BITS-1:0] dcnt_d;
    logic               init_q;
    logic               init_d;
    logic               hi_q;
    logic               lo_q;
    logic               period_end_s;

    assign period_end_s = ovf_in & ena;

    // Compare double buffer and the raw comparator stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_shadow_q <= '0;
            cmp_active_q <= '0;
            upd_pend_q   <= 1'b0;
            raw_q        <= 1'b0;
        end else begin
            if (period_end_s) begin
                // A write landing on the period end bypasses the shadow wait.
                if (cmp_wr) begin
                    cmp_shadow_q <= cmp_in;
                    cmp_active_q <= cmp_in;
                end else begin
                    cmp_active_q <= cmp_shadow_q;
                end
                upd_pend_q <= 1'b0;
            end else if (cmp_wr) begin
                cmp_shadow_q <= cmp_in;
                upd_pend_q   <= 1'b1;
            end
            raw_q <= (cnt_in < cmp_active_q);
        end
    end

    // Next-state logic for the dead-time sequencer.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        init_d  = init_q;
        if (!ena) begin
            init_d = 1'b0;
            if (dt == DT_ZERO) begin
                state_d = ST_LO;
                dcnt_d  = DT_ZERO;
            end else begin
                state_d = ST_DEAD_L;
                dcnt_d  = dt - DT_ONE;
            end
        end else begin
            case (state_q)
                ST_LO: begin
                    if (raw_q) begin
                        if (dt == DT_ZERO) begin
                            state_d = ST_HI;
                        end else begin
                            state_d = ST_DEAD_H;
                            dcnt_d  = dt - DT_ONE;
                        end
                    end else begin
                        state_d = ST_LO;
                    end
                end
                ST_HI: begin
                    if (!raw_q) begin
                        if (dt == DT_ZERO) begin
                            state_d = ST_LO;
                        end else begin
                            state_d = ST_DEAD_L;
                            dcnt_d  = dt - DT_ONE;
                        end
                    end else begin
                        state_d = ST_HI;
                    end
                end
                ST_DEAD_H: begin
                    if (!raw_q) begin
                        state_d = ST_LO;
                    end else if (dcnt_q == DT_ZERO) begin
                        state_d = ST_HI;
                    end else begin
                        dcnt_d = dcnt_q - DT_ONE;
                    end
                end
                ST_DEAD_L: begin
                    if (raw_q) begin
                        state_d = ST_HI;
                        init_d  = 1'b0;
                    end else if (init_q) begin
                        // Leaving reset counts as a dead-phase entry: dt is
                        // sampled here, and this edge is already the first of
                        // the dt dead cycles.
                        init_d = 1'b0;
                        if (dt <= DT_ONE) begin
                            state_d = ST_LO;
                        end else begin
                            dcnt_d = dt - DT_TWO;
                        end
                    end else if (dcnt_q == DT_ZERO) begin
                        state_d = ST_LO;
                    end else begin
                        dcnt_d = dcnt_q - DT_ONE;
                    end
                end
                default: begin
                    state_d = ST_DEAD_L;
                    dcnt_d  = DT_ZERO;
                end
            endcase
        end
    end

    // Sequencer state and registered drive decodes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_DEAD_L;
            dcnt_q  <= DT_ZERO;
            init_q  <= 1'b1;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            init_q  <= init_d;
            hi_q    <= (state_d == ST_HI);
            lo_q    <= (state_d == ST_LO);
        end
    end

    // Polarity is applied after the register so reset is inactive for either pol.
    assign pwm_h    = hi_q ^ pol;
    assign pwm_l    = lo_q ^ pol;
    assign upd_pend = upd_pend_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] cnt_in;
    logic       ovf_in;
    logic [7:0] cmp_in;
    logic       cmp_wr;
    logic [3:0] dt;
    logic       pol;
    logic       pwm_h;
    logic       pwm_l;
    logic       upd_pend;

    pwm_deadtime #(.BITS(8), .DT_BITS(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .cnt_in(cnt_in), .ovf_in(ovf_in),
        .cmp_in(cmp_in), .cmp_wr(cmp_wr), .dt(dt), .pol(pol),
        .pwm_h(pwm_h), .pwm_l(pwm_l), .upd_pend(upd_pend)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Upstream counter emulation
    int top;
    int cnt;

    // Behavioural reference: which side conducts (-1 low, 0 none, +1 high),
    // which side a gap is heading towards, and how long the gap has lasted.
    int m_shadow, m_active;
    bit m_pend, m_raw;
    int m_drive, m_heading, m_off_cnt, m_gap_dt;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow = 0; m_active = 0; m_pend = 1'b0; m_raw = 1'b0;
        m_drive = 0; m_heading = -1; m_off_cnt = 1; m_gap_dt = int'(dt);
    endtask

    task automatic start_gap(input int side);
        m_drive = 0; m_heading = side; m_off_cnt = 1; m_gap_dt = int'(dt);
    endtask

    task automatic model_edge();
        bit old_raw;
        int want;
        old_raw = m_raw;
        m_raw = (int'(cnt_in) < m_active);
        if (ovf_in && ena) begin
            m_active = cmp_wr ? int'(cmp_in) : m_shadow;
            if (cmp_wr) m_shadow = int'(cmp_in);
            m_pend = 1'b0;
        end else if (cmp_wr) begin
            m_shadow = int'(cmp_in);
            m_pend = 1'b1;
        end
        if (!ena) begin
            if (dt == 4'd0) m_drive = -1;
            else start_gap(-1);
        end else begin
            want = old_raw ? 1 : -1;
            if (m_drive != 0) begin
                if (m_drive != want) begin
                    if (dt == 4'd0) m_drive = want;
                    else start_gap(want);
                end
            end else if (want != m_heading) begin
                m_drive = want;              // gap aborted: no dead time needed
            end else if (m_off_cnt >= m_gap_dt) begin
                m_drive = m_heading;
            end else begin
                m_off_cnt++;
            end
        end
    endtask

    task automatic cycle();
        logic exp_h, exp_l;
        cnt_in = 8'(cnt);
        ovf_in = ena && (cnt == top);
        @(posedge clk);
        #1;
        model_edge();
        cmp_wr = 1'b0;
        if (ena) cnt = (cnt == top) ? 0 : cnt + 1;
        exp_h = (m_drive == 1) ^ pol;
        exp_l = (m_drive == -1) ^ pol;
        check("cycle", {5'd0, pwm_h, pwm_l, upd_pend}, {5'd0, exp_h, exp_l, m_pend});
        check("excl", {7'd0, (pwm_h ^ pol) & (pwm_l ^ pol)}, 8'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write_cmp(input int v);
        cmp_in = 8'(v);
        cmp_wr = 1'b1;
        cycle();
    endtask

    task automatic run_until_cnt(input int v);
        int g;
        g = 0;
        while (cnt != v && g < 64) begin cycle(); g++; end
        check("wait_cnt", {7'd0, cnt == v}, 8'd1);
    endtask

    task automatic run_until_drive(input int v);
        int g;
        g = 0;
        while (m_drive != v && g < 64) begin cycle(); g++; end
        check("wait_drive", {7'd0, m_drive == v}, 8'd1);
    endtask

    task automatic window(input int n, output int nh, output int nl);
        nh = 0; nl = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (pwm_h ^ pol) nh++;
            if (pwm_l ^ pol) nl++;
        end
    endtask

    initial begin
        int nh, nl;
        rst = 1'b0; ena = 1'b0; pol = 1'b0; dt = 4'd2; cmp_wr = 1'b0;
        cmp_in = 8'd0; cnt_in = 8'd0; ovf_in = 1'b0; top = 9; cnt = 0;
        model_reset();
        #12;
        check("reset_out", {5'd0, pwm_h, pwm_l, upd_pend}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b1;

        // Dead time: top=9, cmp=4, dt=2
        write_cmp(4);
        run(30);
        window(10, nh, nl);
        check("dt_high_cnt", 8'(nh), 8'd2);
        check("dt_low_cnt", 8'(nl), 8'd4);

        // Shadow update mid-period
        run_until_cnt(2);
        write_cmp(7);
        check("shadow_pend", {7'd0, upd_pend}, 8'd1);
        run_until_cnt(0);
        check("shadow_clr", {7'd0, upd_pend}, 8'd0);
        run(20);

        // Write coincident with period end
        run_until_cnt(top);
        write_cmp(6);
        check("simul_pend", {7'd0, upd_pend}, 8'd0);
        run(20);

        // Short pulse: cmp=1, dt=3
        dt = 4'd3;
        write_cmp(1);
        run(30);
        window(10, nh, nl);
        check("short_high", 8'(nh), 8'd0);
        check("short_low", 8'(nl), 8'd9);

        // Disable in HI with inverted polarity
        pol = 1'b1; dt = 4'd2;
        write_cmp(5);
        run(25);
        run_until_drive(1);
        ena = 1'b0;
        cycle();
        check("dis_out", {6'd0, pwm_h, pwm_l}, 8'd3);
        run(3);
        ena = 1'b1;
        run(20);

        // Asynchronous reset in HI, release with dt=3
        pol = 1'b0; dt = 4'd3;
        write_cmp(6);
        run(20);
        run_until_drive(1);
        cmp_in = 8'd8; cmp_wr = 1'b1;
        cycle();
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", {5'd0, pwm_h, pwm_l, upd_pend}, 8'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cnt = 1;
        cycle();
        check("rst_rel1", {7'd0, pwm_l}, 8'd0);
        cycle();
        check("rst_rel2", {7'd0, pwm_l}, 8'd0);
        cycle();
        check("rst_rel3", {7'd0, pwm_l}, 8'd1);

        // Randomized operation against the reference
        write_cmp(3);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15, 0) == 0) dt = 4'($urandom_range(5, 0));
            if ($urandom_range(7, 0) == 0) begin
                cmp_in = 8'($urandom_range(top + 2, 0));
                cmp_wr = 1'b1;
            end
            if ($urandom_range(31, 0) == 0) ena = ~ena;
            if ($urandom_range(63, 0) == 0) pol = ~pol;
            if (cnt == 0 && $urandom_range(49, 0) == 0) top = $urandom_range(15, 2);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
